// File: rtl/imm_gen_pkg.sv
// rtl/imm_gen_pkg.sv - shared types and opcodes for the buffered immediate generator
package imm_gen_pkg;

  // Format code carried with every decoded immediate
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_R    = 3'd6,
    FMT_Z    = 3'd7
  } imm_fmt_e;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Storage width for a buffered immediate; covers the widest legal XLEN
  localparam int IMM_W = 64;

  typedef struct packed {
    imm_fmt_e         fmt;
    logic [IMM_W-1:0] imm;
  } imm_entry_t;

  // R-type rides the imm field for the comparison flag, so it does not count as an immediate
  function automatic logic fmt_has_imm(input imm_fmt_e f);
    return (f != FMT_NONE) && (f != FMT_R);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational immediate decode; IMM_CSR_ZIMM_EN enables CSR zimm (fmt Z)
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr,
  input  logic            slt_flag,
  output imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);

  // Every format fits in 32 bits with its sign at bit 31, so one sign extension serves all
  logic [31:0] imm32;

  // Select format and assemble the 32-bit immediate from the opcode
  always_comb begin
    fmt   = FMT_NONE;
    imm32 = '0;
    case (instr[6:0])
      OPC_OP_IMM, OPC_OP_IMM32, OPC_LOAD, OPC_JALR: begin
        fmt   = FMT_I;
        imm32 = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_SYSTEM: begin
`ifdef IMM_CSR_ZIMM_EN
        if (instr[14]) begin
          fmt   = FMT_Z;
          imm32 = {27'b0, instr[19:15]};
        end else begin
          fmt   = FMT_I;
          imm32 = {{20{instr[31]}}, instr[31:20]};
        end
`else
        fmt   = FMT_I;
        imm32 = {{20{instr[31]}}, instr[31:20]};
`endif
      end
      OPC_STORE: begin
        fmt   = FMT_S;
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        fmt   = FMT_B;
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt   = FMT_U;
        imm32 = {instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        fmt   = FMT_J;
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OPC_OP, OPC_OP32: begin
        fmt   = FMT_R;
        imm32 = {31'b0, slt_flag};
      end
      default: begin
        fmt   = FMT_NONE;
        imm32 = '0;
      end
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - immediate decode feeding a DEPTH-entry valid/ready FIFO; IMM_CSR_ZIMM_EN passes to imm_decode
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic            slt_flag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt,
  output logic            has_imm
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  imm_entry_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  imm_fmt_e        dec_fmt;
  logic [XLEN-1:0] dec_imm;
  imm_entry_t      head;
  logic            push;
  logic            pop;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr    (instr),
    .slt_flag (slt_flag),
    .fmt      (dec_fmt),
    .imm      (dec_imm)
  );

  // Readiness comes only from registered count, never from out_ready
  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Entry storage is not reset; count alone says which slots are live
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{fmt: dec_fmt, imm: IMM_W'($signed(dec_imm))};
    end
  end

  // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head outputs are forced to zero/NONE when empty so stale storage never shows
  assign head    = mem[rd_ptr];
  assign imm     = out_valid ? head.imm[XLEN-1:0] : '0;
  assign fmt     = out_valid ? head.fmt : FMT_NONE;
  assign has_imm = out_valid && fmt_has_imm(head.fmt);

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - scoreboard bench for imm_gen_pipe with a behavioural decode model
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  localparam int XLEN  = 64;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic        slt_flag = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] imm;
  imm_fmt_e    fmt;
  logic        has_imm;

  logic [2:0]  drv_fmt = '0;
  logic [63:0] drv_imm = '0;

  typedef struct {
    logic [2:0]  f;
    logic [63:0] v;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad = 0;

  imm_gen_pipe #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .slt_flag  (slt_flag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .imm       (imm),
    .fmt       (fmt),
    .has_imm   (has_imm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Reference decode from the instruction-format rules, using plain integer arithmetic
  function automatic void ref_dec(input logic [31:0] w, input logic s,
                                  output logic [2:0] f, output logic [63:0] v);
    longint x;
    f = FMT_NONE;
    x = 0;
    case (w[6:0])
      7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111: begin
        f = FMT_I;
        x = longint'(w[31:20]);
        if (x >= 2048) x -= 4096;
      end
      7'b1110011: begin
`ifdef IMM_CSR_ZIMM_EN
        if (w[14]) begin
          f = FMT_Z;
          x = longint'(w[19:15]);
        end else begin
          f = FMT_I;
          x = longint'(w[31:20]);
          if (x >= 2048) x -= 4096;
        end
`else
        f = FMT_I;
        x = longint'(w[31:20]);
        if (x >= 2048) x -= 4096;
`endif
      end
      7'b0100011: begin
        f = FMT_S;
        x = longint'(w[31:25]) * 32 + longint'(w[11:7]);
        if (x >= 2048) x -= 4096;
      end
      7'b1100011: begin
        f = FMT_B;
        x = longint'(w[31]) * 4096 + longint'(w[7]) * 2048
          + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
        if (x >= 4096) x -= 8192;
      end
      7'b0110111, 7'b0010111: begin
        f = FMT_U;
        x = longint'(w[31:12]) * 4096;
        if (x >= 64'sd2147483648) x -= 64'sd4294967296;
      end
      7'b1101111: begin
        f = FMT_J;
        x = longint'(w[31]) * 1048576 + longint'(w[19:12]) * 4096
          + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
        if (x >= 1048576) x -= 2097152;
      end
      7'b0110011, 7'b0111011: begin
        f = FMT_R;
        x = s ? 1 : 0;
      end
      default: begin
        f = FMT_NONE;
        x = 0;
      end
    endcase
    v = 64'(x);
  endfunction

  // Monitor: model occupancy, check handshakes, pop on accept, push on accept
  bit          live = 0;
  bit          post_rst = 0;
  bit          hold_v = 0;
  logic [63:0] hold_imm;
  logic [2:0]  hold_fmt;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb.delete();
        live = 1;
        post_rst = 1;
        hold_v = 0;
      end else if (live) begin
        if (post_rst) begin
          chk("rst_out_valid", out_valid, 0);
          chk("rst_in_ready", in_ready, 1);
          chk("rst_fmt", fmt, FMT_NONE);
          chk("rst_imm", imm, 0);
          chk("rst_has_imm", has_imm, 0);
          post_rst = 0;
        end
        chk("in_ready", in_ready, sb.size() != DEPTH);
        chk("out_valid", out_valid, sb.size() != 0);
        if (hold_v) begin
          chk("stall_imm", imm, hold_imm);
          chk("stall_fmt", fmt, hold_fmt);
        end
        hold_v   = out_valid && !out_ready;
        hold_imm = imm;
        hold_fmt = fmt;
        if (out_valid && out_ready && sb.size() != 0) begin
          e = sb.pop_front();
          chk("imm", imm, e.v);
          chk("fmt", fmt, e.f);
          chk("has_imm", has_imm, (e.f != FMT_NONE) && (e.f != FMT_R));
        end
        if (in_valid && in_ready) sb.push_back('{drv_fmt, drv_imm});
      end
    end
  end

  // Present one instruction and hold it until accepted, bounded
  task automatic push(input logic [31:0] w, input logic s, input logic [2:0] f, input logic [63:0] v);
    bit ok;
    instr = w;
    slt_flag = s;
    drv_fmt = f;
    drv_imm = v;
    in_valid = 1'b1;
    ok = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL push_timeout: got 0 want 1");
    end
  endtask

  task automatic push_m(input logic [31:0] w, input logic s);
    logic [2:0]  f;
    logic [63:0] v;
    ref_dec(w, s, f, v);
    push(w, s, f, v);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    chk("drain_left", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  logic [6:0] opc_tab [12] = '{7'b0110011, 7'b0010011, 7'b0011011, 7'b0111011,
                               7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111,
                               7'b1101111, 7'b0110111, 7'b0010111, 7'b1110011};

  initial begin
    logic [31:0] w;
    logic [2:0]  f;
    logic [63:0] v;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    out_ready = 1'b1;
    push(32'hFFF00093, 1'b0, FMT_I, 64'hFFFF_FFFF_FFFF_FFFF);
    push(32'hFE113C23, 1'b0, FMT_S, 64'hFFFF_FFFF_FFFF_FFF8);
    push(32'hFE000EE3, 1'b0, FMT_B, 64'hFFFF_FFFF_FFFF_FFFC);
    push(32'h800002B7, 1'b0, FMT_U, 64'hFFFF_FFFF_8000_0000);
    push(32'h0010006F, 1'b0, FMT_J, 64'h0000_0000_0000_0800);
    push(32'h00208033, 1'b1, FMT_R, 64'h1);
    push(32'h0000007F, 1'b1, FMT_NONE, 64'h0);
    drain();

    out_ready = 1'b0;
    fork
      begin
        push_m(32'h00100093, 1'b0);
        push_m(32'h00200113, 1'b0);
        push_m(32'h00300193, 1'b0);
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    out_ready = 1'b0;
    push_m(32'h7FF00093, 1'b0);
    push_m(32'h80000137, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    push_m(32'hFFDFF06F, 1'b0);
    drain();

    for (int c = 0; c < 400; c++) begin
      w = $urandom;
      if ($urandom_range(0, 7) != 0) w[6:0] = opc_tab[$urandom_range(0, 11)];
      ref_dec(w, 1'($urandom), f, v);
      slt_flag = v[0] & (f == FMT_R);
      instr = w;
      drv_fmt = f;
      drv_imm = v;
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      reset = ($urandom_range(0, 99) == 0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
